// File: rtl/game_pkg.sv
// Shared game-side definitions: bus word width, score width and the
// Wishbone initiator state encoding.
package game_pkg;

  localparam int DATA_W  = 32;
  localparam int SCORE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    GAP  = 2'd3
  } wbm_state_t;

endpackage

// File: rtl/poll_timer.sv
// Free-running period timer: counts while enabled, emits a one-cycle tick on
// the last count of each period and wraps. Disabling holds it at zero so the
// first period after enable is always a full one.
module poll_timer #(
  parameter int PERIOD = 100_000,
  parameter int CNT_W  = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Period counter: hold at zero when disabled, wrap on the tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_score_master.sv
// Wishbone classic initiator for the score/VGA register slave. Polls the
// score word periodically (or on demand), performs single-beat control
// writes, and aborts any cycle whose ack does not arrive in time.
module wb_score_master
  import game_pkg::*;
#(
  parameter int POLL_PERIOD = 100_000,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                poll_en,
  input  logic                rd_req,
  input  logic                wr_req,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                wb_m2s_cyc,
  output logic                wb_m2s_stb,
  output logic                wb_m2s_we,
  output logic [DATA_W-1:0]   wb_m2s_dat,
  input  logic [DATA_W-1:0]   wb_s2m_dat,
  input  logic                wb_s2m_ack,
  output logic [SCORE_W-1:0]  score,
  output logic                score_changed,
  output logic                wr_done,
  output logic                timeout_err,
  output logic                busy
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  wbm_state_t        state;
  logic              rd_pend;
  logic              wr_pend;
  logic [DATA_W-1:0] wr_latch;
  logic [CNT_W-1:0]  to_cnt;
  logic              poll_tick;
  logic              start_wr;
  logic              start_rd;
  logic              unused_rd_hi;

  // Upper half of the read word carries no score information.
  assign unused_rd_hi = ^wb_s2m_dat[DATA_W-1:SCORE_W];

  // Writes win arbitration; a read waits behind a pending write.
  assign start_wr = (state == IDLE) && wr_pend;
  assign start_rd = (state == IDLE) && !wr_pend && rd_pend;

  poll_timer #(
    .PERIOD (POLL_PERIOD),
    .CNT_W  (CNT_W)
  ) u_poll_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (poll_en),
    .tick    (poll_tick)
  );

  // Pending requests: a new request in the same cycle as launch stays queued
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_pend  <= 1'b0;
      rd_pend  <= 1'b0;
      wr_latch <= '0;
    end else begin
      if (wr_req) begin
        wr_pend  <= 1'b1;
        wr_latch <= wr_data;
      end else if (start_wr) begin
        wr_pend <= 1'b0;
      end
      if (rd_req || poll_tick) begin
        rd_pend <= 1'b1;
      end else if (start_rd) begin
        rd_pend <= 1'b0;
      end
    end
  end

  // Bus FSM with registered Wishbone and status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      wb_m2s_cyc    <= 1'b0;
      wb_m2s_stb    <= 1'b0;
      wb_m2s_we     <= 1'b0;
      wb_m2s_dat    <= '0;
      score         <= '0;
      score_changed <= 1'b0;
      wr_done       <= 1'b0;
      timeout_err   <= 1'b0;
      busy          <= 1'b0;
      to_cnt        <= '0;
    end else begin
      score_changed <= 1'b0;
      wr_done       <= 1'b0;
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (start_wr) begin
            state      <= WR;
            wb_m2s_cyc <= 1'b1;
            wb_m2s_stb <= 1'b1;
            wb_m2s_we  <= 1'b1;
            wb_m2s_dat <= wr_latch;
            busy       <= 1'b1;
          end else if (start_rd) begin
            state      <= RD;
            wb_m2s_cyc <= 1'b1;
            wb_m2s_stb <= 1'b1;
            wb_m2s_we  <= 1'b0;
            busy       <= 1'b1;
          end
        end
        WR, RD: begin
          if (wb_s2m_ack) begin
            state       <= GAP;
            wb_m2s_cyc  <= 1'b0;
            wb_m2s_stb  <= 1'b0;
            wb_m2s_we   <= 1'b0;
            timeout_err <= 1'b0;
            if (state == WR) begin
              wr_done <= 1'b1;
            end else begin
              score         <= wb_s2m_dat[SCORE_W-1:0];
              score_changed <= (wb_s2m_dat[SCORE_W-1:0] != score);
            end
          end else if (to_cnt == TO_LAST) begin
            state       <= GAP;
            wb_m2s_cyc  <= 1'b0;
            wb_m2s_stb  <= 1'b0;
            wb_m2s_we   <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end
        GAP: begin
          // One idle bus cycle so the slave's ack toggle cannot re-fire.
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_score_master.sv
// Bench for wb_score_master: a behavioural Wishbone slave with programmable
// ack latency, a bus monitor that logs completed transfers, and per-feature
// scenario tasks comparing against expectations derived from the bus rules.
module tb_wb_score_master;

  localparam int POLL_PERIOD = 8;
  localparam int TIMEOUT_CYC = 16;

  typedef struct packed {
    logic        we;
    logic [31:0] dat;
  } tx_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        poll_en = 1'b0;
  logic        rd_req = 1'b0;
  logic        wr_req = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wb_m2s_cyc;
  logic        wb_m2s_stb;
  logic        wb_m2s_we;
  logic [31:0] wb_m2s_dat;
  logic [31:0] wb_s2m_dat;
  logic        wb_s2m_ack = 1'b0;
  logic [15:0] score;
  logic        score_changed;
  logic        wr_done;
  logic        timeout_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_score_master #(
    .POLL_PERIOD (POLL_PERIOD),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (32)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .poll_en       (poll_en),
    .rd_req        (rd_req),
    .wr_req        (wr_req),
    .wr_data       (wr_data),
    .wb_m2s_cyc    (wb_m2s_cyc),
    .wb_m2s_stb    (wb_m2s_stb),
    .wb_m2s_we     (wb_m2s_we),
    .wb_m2s_dat    (wb_m2s_dat),
    .wb_s2m_dat    (wb_s2m_dat),
    .wb_s2m_ack    (wb_s2m_ack),
    .score         (score),
    .score_changed (score_changed),
    .wr_done       (wr_done),
    .timeout_err   (timeout_err),
    .busy          (busy)
  );

  // Slave: one register, acks ack_delay cycles after stb is first seen
  logic [31:0] slave_reg = '0;
  logic [31:0] load_val = '0;
  logic        load_en = 1'b0;
  logic        slave_ack_en = 1'b1;
  int          ack_delay = 2;
  int          stb_age = 0;

  assign wb_s2m_dat = slave_reg;

  always @(posedge clk) begin
    if (load_en) slave_reg <= load_val;
    if (wb_m2s_stb && !wb_s2m_ack) begin
      stb_age = stb_age + 1;
      if (slave_ack_en && stb_age >= ack_delay) begin
        wb_s2m_ack <= 1'b1;
        if (wb_m2s_we) slave_reg <= wb_m2s_dat;
      end
    end else begin
      stb_age = 0;
      wb_s2m_ack <= 1'b0;
    end
  end

  // Monitor: completed transfers, stb rises, high/low run lengths
  tx_t txq[$];
  int  rise_q[$];
  int  rises = 0;
  int  cyc_n = 0;
  int  hi_len = 0;
  int  lo_len = 0;
  int  last_hi = 0;
  int  last_gap = 0;
  logic stb_prev = 1'b0;

  always @(posedge clk) begin
    cyc_n = cyc_n + 1;
    if (!reset_n) begin
      stb_prev = 1'b0;
      hi_len = 0;
      lo_len = 0;
    end else begin
      if (wb_m2s_stb && !stb_prev) begin
        rises = rises + 1;
        rise_q.push_back(cyc_n);
        last_gap = lo_len;
        hi_len = 0;
        lo_len = 0;
      end
      if (!wb_m2s_stb && stb_prev) last_hi = hi_len;
      if (wb_m2s_stb) hi_len = hi_len + 1;
      else lo_len = lo_len + 1;
      if (wb_m2s_stb && wb_s2m_ack) txq.push_back({wb_m2s_we, wb_s2m_ack && wb_m2s_we ? wb_m2s_dat : wb_s2m_dat});
      stb_prev = wb_m2s_stb;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_slave(input logic [31:0] v);
    load_val = v;
    load_en = 1'b1;
    step(1);
    load_en = 1'b0;
  endtask

  task automatic pulse_rd();
    rd_req = 1'b1;
    step(1);
    rd_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while (busy && k < budget) begin
      step(1);
      k++;
    end
    n_checks++;
    if (busy) begin
      n_fail++;
      $display("FAIL %s idle_wait: busy still %b after %0d cycles, required 0", name, busy, budget);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(2);
    n_checks++;
    if ({wb_m2s_cyc, wb_m2s_stb, wb_m2s_we, score_changed, wr_done, timeout_err, busy} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, required 0000000",
               {wb_m2s_cyc, wb_m2s_stb, wb_m2s_we, score_changed, wr_done, timeout_err, busy});
    end
    n_checks++;
    if (wb_m2s_dat !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_dat: got %h, required 0", wb_m2s_dat);
    end
    n_checks++;
    if (score !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_score: got %h, required 0", score);
    end
    reset_n = 1'b1;
    step(12);
    n_checks++;
    if (rises !== 0) begin
      n_fail++;
      $display("FAIL reset_quiet: %0d transfers without a request, required 0", rises);
    end
  endtask

  // Poll at POLL_PERIOD: one read per period, score 3, a single change pulse
  task automatic test_poll_read();
    int changes;
    int r0;
    int window;
    int exp_reads;
    logic [15:0] v;
    changes = 0;
    window = 44;
    exp_reads = (window - 1) / POLL_PERIOD;
    ack_delay = $urandom_range(2, 4);
    load_slave(32'h0000_0003);
    txq.delete();
    rise_q.delete();
    r0 = rises;
    poll_en = 1'b1;
    for (int i = 0; i < window; i++) begin
      step(1);
      if (score_changed) changes++;
    end
    poll_en = 1'b0;
    step(10);
    n_checks++;
    if (rises - r0 !== exp_reads) begin
      n_fail++;
      $display("FAIL poll_count: %0d reads, required %0d", rises - r0, exp_reads);
    end
    for (int i = 1; i < rise_q.size(); i++) begin
      n_checks++;
      if (rise_q[i] - rise_q[i-1] !== POLL_PERIOD) begin
        n_fail++;
        $display("FAIL poll_spacing: %0d clks between reads, required %0d", rise_q[i] - rise_q[i-1], POLL_PERIOD);
      end
    end
    foreach (txq[i]) begin
      n_checks++;
      if (txq[i] !== {1'b0, 32'h0000_0003}) begin
        n_fail++;
        $display("FAIL poll_tx: we/dat %b/%h, required 0/00000003", txq[i].we, txq[i].dat);
      end
    end
    n_checks++;
    if (score !== 16'h0003) begin
      n_fail++;
      $display("FAIL poll_score: got %h, required 0003", score);
    end
    n_checks++;
    if (changes !== 1) begin
      n_fail++;
      $display("FAIL poll_changed: %0d pulses, required 1", changes);
    end
    // New value on the slave: exactly one more change pulse
    do v = 16'($urandom); while (v == 16'h0003);
    load_slave({16'($urandom), v});
    changes = 0;
    poll_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (score_changed) changes++;
    end
    poll_en = 1'b0;
    step(10);
    n_checks++;
    if (score !== v || changes !== 1) begin
      n_fail++;
      $display("FAIL poll_newval: score %h pulses %0d, required %h and 1", score, changes, v);
    end
  endtask

  task automatic test_write();
    logic [31:0] d;
    int k;
    for (int i = 0; i < 4; i++) begin
      d = (i == 0) ? 32'h0000_6004 : $urandom;
      ack_delay = $urandom_range(2, 4);
      txq.delete();
      wr_data = d;
      wr_req = 1'b1;
      step(1);
      wr_req = 1'b0;
      wr_data = ~d;
      k = 0;
      while (!wr_done && k < 40) begin
        step(1);
        k++;
      end
      n_checks++;
      if (!wr_done) begin
        n_fail++;
        $display("FAIL wr_done_wait: no wr_done within 40 cycles, required a pulse");
      end else begin
        n_checks++;
        if (wb_m2s_stb !== 1'b0 || wb_m2s_cyc !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL wr_gap: stb/cyc/busy %b%b%b in GAP, required 001", wb_m2s_stb, wb_m2s_cyc, busy);
        end
        step(1);
        n_checks++;
        if (wr_done !== 1'b0 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL wr_pulse: wr_done/busy %b%b after pulse, required 00", wr_done, busy);
        end
      end
      n_checks++;
      if (slave_reg !== d) begin
        n_fail++;
        $display("FAIL wr_slave_reg: got %h, required %h", slave_reg, d);
      end
      n_checks++;
      if (txq.size() !== 1 || txq[0] !== {1'b1, d}) begin
        n_fail++;
        $display("FAIL wr_tx: %0d transfers, first %h, required 1 write of %h", txq.size(), txq.size() > 0 ? txq[0].dat : 32'h0, d);
      end
    end
  endtask

  // Same-cycle write and read: write first, then read of the new word
  task automatic test_priority();
    logic [31:0] d;
    int k;
    d = $urandom;
    ack_delay = $urandom_range(2, 4);
    txq.delete();
    wr_data = d;
    wr_req = 1'b1;
    rd_req = 1'b1;
    step(1);
    wr_req = 1'b0;
    rd_req = 1'b0;
    k = 0;
    while (txq.size() < 2 && k < 60) begin
      step(1);
      k++;
    end
    step(3);
    n_checks++;
    if (txq.size() !== 2) begin
      n_fail++;
      $display("FAIL prio_count: %0d transfers, required 2", txq.size());
    end else begin
      n_checks++;
      if (txq[0] !== {1'b1, d} || txq[1] !== {1'b0, d}) begin
        n_fail++;
        $display("FAIL prio_order: %b/%h then %b/%h, required 1/%h then 0/%h",
                 txq[0].we, txq[0].dat, txq[1].we, txq[1].dat, d, d);
      end
    end
    // stb low for the GAP cycle plus the IDLE arbitration cycle
    n_checks++;
    if (last_gap !== 2) begin
      n_fail++;
      $display("FAIL prio_gap: stb low %0d cycles between transfers, required 2", last_gap);
    end
    n_checks++;
    if (score !== d[15:0]) begin
      n_fail++;
      $display("FAIL prio_score: got %h, required %h", score, d[15:0]);
    end
  endtask

  // Requests during a busy transfer are queued; repeated writes keep the last data
  task automatic test_queue();
    logic [31:0] a;
    logic [31:0] b;
    int k;
    a = $urandom;
    b = $urandom;
    ack_delay = 4;
    txq.delete();
    pulse_rd();
    step(1);
    wr_data = a;
    wr_req = 1'b1;
    step(1);
    wr_data = b;
    step(1);
    wr_req = 1'b0;
    k = 0;
    while (txq.size() < 2 && k < 60) begin
      step(1);
      k++;
    end
    step(12);
    n_checks++;
    if (txq.size() !== 2) begin
      n_fail++;
      $display("FAIL queue_count: %0d transfers, required 2", txq.size());
    end else begin
      n_checks++;
      if (txq[0].we !== 1'b0 || txq[1] !== {1'b1, b}) begin
        n_fail++;
        $display("FAIL queue_last_wins: second we/dat %b/%h, required 1/%h", txq[1].we, txq[1].dat, b);
      end
    end
  endtask

  task automatic test_timeout();
    logic [15:0] s0;
    logic [31:0] r0;
    logic [31:0] v;
    int pulses;
    s0 = score;
    r0 = slave_reg;
    slave_ack_en = 1'b0;
    txq.delete();
    pulse_rd();
    step(2);
    wait_idle(60, "timeout_rd");
    n_checks++;
    if (last_hi !== TIMEOUT_CYC) begin
      n_fail++;
      $display("FAIL timeout_len: stb high %0d cycles, required %0d", last_hi, TIMEOUT_CYC);
    end
    n_checks++;
    if (timeout_err !== 1'b1 || score !== s0) begin
      n_fail++;
      $display("FAIL timeout_rd: err %b score %h, required 1 and %h", timeout_err, score, s0);
    end
    pulses = 0;
    wr_data = ~r0;
    wr_req = 1'b1;
    step(1);
    wr_req = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (wr_done) pulses++;
    end
    n_checks++;
    if (pulses !== 0 || slave_reg !== r0 || timeout_err !== 1'b1 || txq.size() !== 0) begin
      n_fail++;
      $display("FAIL timeout_wr: wr_done %0d reg %h err %b, required 0, %h, 1", pulses, slave_reg, timeout_err, r0);
    end
    slave_ack_en = 1'b1;
    do v = $urandom; while (v[15:0] == score);
    load_slave(v);
    pulse_rd();
    step(2);
    wait_idle(40, "timeout_recover");
    n_checks++;
    if (timeout_err !== 1'b0 || score !== v[15:0]) begin
      n_fail++;
      $display("FAIL timeout_clear: err %b score %h, required 0 and %h", timeout_err, score, v[15:0]);
    end
  endtask

  // Reset mid-transfer: bus drops asynchronously, pending write discarded
  task automatic test_reset_mid();
    int r0;
    slave_ack_en = 1'b0;
    pulse_rd();
    step(2);
    wr_data = $urandom;
    wr_req = 1'b1;
    step(1);
    wr_req = 1'b0;
    n_checks++;
    if (wb_m2s_stb !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: stb %b before reset, required 1", wb_m2s_stb);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (wb_m2s_stb !== 1'b0 || wb_m2s_cyc !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: stb/cyc %b%b in reset cycle, required 00", wb_m2s_stb, wb_m2s_cyc);
    end
    slave_ack_en = 1'b1;
    step(2);
    reset_n = 1'b1;
    r0 = rises;
    step(20);
    n_checks++;
    if (rises !== r0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_quiet: %0d transfers busy %b after release, required 0 and 0", rises - r0, busy);
    end
    pulse_rd();
    step(12);
    n_checks++;
    if (rises !== r0 + 1 || score !== slave_reg[15:0]) begin
      n_fail++;
      $display("FAIL rstmid_resume: %0d transfers score %h, required 1 and %h", rises - r0, score, slave_reg[15:0]);
    end
  endtask

  initial begin
    test_reset();
    test_poll_read();
    test_write();
    test_priority();
    test_queue();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit, required completion");
    $fatal(1);
  end

endmodule
